// File: rtl/edf_ic_pkg.sv
// Shared definitions for the EDF interrupt controller: config map, scheduler states
// and the default deadline width.
package edf_ic_pkg;

  localparam int DEFAULT_DL_WIDTH = 16;

  localparam logic [11:0] ADDR_DL_BASE = 12'h000;
  localparam logic [11:0] ADDR_EN      = 12'h100;
  localparam logic [11:0] ADDR_MISS    = 12'h104;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FLUSH
  } sched_state_e;

endpackage

// File: rtl/edf_dl_cmp.sv
// Wrap-aware deadline comparator: a is earlier when (a_dl - b_dl) is negative as a
// signed DlWidth value; equal deadlines fall back to the lower id.
module edf_dl_cmp #(
  parameter int DlWidth = 16,
  parameter int IdWidth = 1
) (
  input  logic [DlWidth-1:0] a_dl,
  input  logic [DlWidth-1:0] b_dl,
  input  logic [IdWidth-1:0] a_id,
  input  logic [IdWidth-1:0] b_id,
  output logic               a_earlier
);

  logic [DlWidth-1:0] diff;

  assign diff      = a_dl - b_dl;
  assign a_earlier = diff[DlWidth-1] | ((diff == '0) & (a_id < b_id));

endmodule

// File: rtl/edf_sched.sv
// Earliest-deadline-first scheduler: arms pending entries on irq rising edges and
// offers the earliest one to the core. Optional deadline-miss flags: EDF_IC_DL_MISS_EN.
module edf_sched
  import edf_ic_pkg::*;
#(
  parameter  int NrParIrqs = 2,
  parameter  int DlWidth   = DEFAULT_DL_WIDTH,
  localparam int IdWidth   = $clog2(NrParIrqs)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_req_i,
  input  logic [31:0]          cfg_addr_i,
  input  logic [31:0]          cfg_wdata_i,
  input  logic [NrParIrqs-1:0] irq_i,
  output logic                 irq_valid_o,
  output logic [IdWidth-1:0]   irq_id_o,
  input  logic                 irq_ready_i
`ifdef EDF_IC_DL_MISS_EN
  ,
  output logic [NrParIrqs-1:0] dl_miss_o
`endif
);

  logic [DlWidth-1:0]   time_q;
  logic [NrParIrqs-1:0] irq_q;
  logic [NrParIrqs-1:0] pending;
  logic [DlWidth-1:0]   rel_dl [NrParIrqs];
  logic [DlWidth-1:0]   abs_dl [NrParIrqs];
  logic                 enable;

  sched_state_e         state;
  logic [IdWidth-1:0]   ptr;
  logic [IdWidth-1:0]   best;
  logic                 found;

  logic [11:0]          addr;
  logic [NrParIrqs-1:0] rise;
  logic [NrParIrqs-1:0] arm;
  logic [NrParIrqs-1:0] clr;
  logic                 claim;
  logic                 ptr_earlier;
  logic                 take;
  logic                 next_found;
  logic [IdWidth-1:0]   next_best;
  logic                 last;
  logic                 unused_cfg;

  assign addr       = cfg_addr_i[11:0];
  assign unused_cfg = ^{cfg_addr_i[31:12], cfg_wdata_i[31:DlWidth]};
  assign rise       = irq_i & ~irq_q;
  assign claim      = irq_valid_o & irq_ready_i;

  // A new edge on the line being claimed re-arms it instead of letting the claim clear it.
  always_comb begin
    arm = '0;
    clr = '0;
    for (int i = 0; i < NrParIrqs; i++) begin
      clr[i] = claim & (irq_id_o == IdWidth'(i));
      arm[i] = rise[i] & enable & (~pending[i] | clr[i]);
    end
  end

  edf_dl_cmp #(
    .DlWidth(DlWidth),
    .IdWidth(IdWidth)
  ) u_cmp (
    .a_dl     (abs_dl[ptr]),
    .b_dl     (abs_dl[best]),
    .a_id     (ptr),
    .b_id     (best),
    .a_earlier(ptr_earlier)
  );

  assign take       = pending[ptr] & (~found | ptr_earlier);
  assign next_found = found | take;
  assign next_best  = take ? ptr : best;
  assign last       = (ptr == IdWidth'(NrParIrqs - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      time_q  <= '0;
      irq_q   <= '0;
      pending <= '0;
      enable  <= 1'b0;
      for (int i = 0; i < NrParIrqs; i++) begin
        rel_dl[i] <= '0;
        abs_dl[i] <= '0;
      end
    end else begin
      time_q <= time_q + DlWidth'(1);
      irq_q  <= irq_i;
      for (int i = 0; i < NrParIrqs; i++) begin
        if (arm[i]) begin
          pending[i] <= 1'b1;
          abs_dl[i]  <= time_q + rel_dl[i];
        end else if (clr[i]) begin
          pending[i] <= 1'b0;
        end
      end
      if (cfg_req_i) begin
        for (int i = 0; i < NrParIrqs; i++) begin
          if (addr == ADDR_DL_BASE + 12'(4 * i)) rel_dl[i] <= cfg_wdata_i[DlWidth-1:0];
        end
        if (addr == ADDR_EN) enable <= cfg_wdata_i[0];
      end
    end
  end

  // The offered id only changes at a pass boundary; a claim aborts the pass in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ptr         <= '0;
      best        <= '0;
      found       <= 1'b0;
      irq_valid_o <= 1'b0;
      irq_id_o    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ptr         <= '0;
          best        <= '0;
          found       <= 1'b0;
          irq_valid_o <= 1'b0;
          if (|pending) state <= SCAN;
        end
        SCAN: begin
          if (claim) begin
            state       <= FLUSH;
            irq_valid_o <= 1'b0;
            ptr         <= '0;
            best        <= '0;
            found       <= 1'b0;
          end else if (last) begin
            irq_id_o    <= next_best;
            irq_valid_o <= next_found & pending[next_best];
            ptr         <= '0;
            best        <= '0;
            found       <= 1'b0;
            if (!next_found) state <= IDLE;
          end else begin
            ptr   <= ptr + IdWidth'(1);
            best  <= next_best;
            found <= next_found;
          end
        end
        FLUSH: begin
          irq_valid_o <= 1'b0;
          ptr         <= '0;
          best        <= '0;
          found       <= 1'b0;
          state       <= (|pending) ? SCAN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EDF_IC_DL_MISS_EN
  // Sticky miss flags; a miss in the same cycle as its write-1-to-clear is kept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dl_miss_o <= '0;
    end else begin
      for (int i = 0; i < NrParIrqs; i++) begin
        if (pending[i] && (time_q == abs_dl[i])) begin
          dl_miss_o[i] <= 1'b1;
        end else if (cfg_req_i && (addr == ADDR_MISS) && cfg_wdata_i[i]) begin
          dl_miss_o[i] <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: doc/edf_sched.md
# edf_sched

Earliest-deadline-first scheduler for the EDF interrupt controller. It holds per-interrupt relative deadlines written over the config port, and converts each rising edge on `irq_i` into a pending entry stamped with an absolute deadline. A sequential scan, one entry per cycle, selects the pending entry with the earliest deadline, and presents it to the core over a valid/ready claim handshake. It sits between the parallel IRQ lines and the core's interrupt interface, alongside `seq_prio_queue`.

## Interface
- `NrParIrqs`, 2: number of interrupt lines; must be ≥2.
- `DlWidth`, 16: width of the timestamp and deadline values.
- `IdWidth`, `$clog2(NrParIrqs)`: localparam, width of the interrupt id.
- `clk_i`  in  1  clock; the single clock of the block.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `cfg_req_i`  in  1  config write strobe; one write per cycle it is high.
- `cfg_addr_i`  in  32  byte address of the config write.
- `cfg_wdata_i`  in  32  config write data.
- `irq_i`  in  NrParIrqs  interrupt lines; an event is a rising edge.
- `irq_valid_o`  out  1  a selected interrupt is being offered to the core.
- `irq_id_o`  out  IdWidth  id of the selected interrupt.
- `irq_ready_i`  in  1  core claim; the claim completes when `irq_valid_o & irq_ready_i`.

## Operation
- **Config map** (only `cfg_addr_i[11:0]` is decoded; writes to any other address are ignored):
  - `0x000 + 4*i` with i < NrParIrqs: `rel_dl[i] = wdata[DlWidth-1:0]`.
  - `0x100`: `enable = wdata[0]`.
- **Time counter:** `time_q` is a free-running DlWidth counter that increments every cycle and wraps modulo 2^DlWidth.
- **Arming:**
  - `irq_q` registers `irq_i`. A rising edge is `irq_i & ~irq_q`.
  - An edge on line i with `enable=1` and `pending[i]=0` sets `pending[i]` and loads `abs_dl[i] = time_q + rel_dl[i]` (mod 2^DlWidth).
  - An edge while `pending[i]=1` is dropped.
  - An edge with `enable=0` is dropped.
- **Comparison:** entry a is earlier than b when the DlWidth-bit difference `abs_dl[a]-abs_dl[b]`, read as signed, is negative. On a tie the lower index wins. The comparison is valid while all live deadlines lie within 2^(DlWidth-1) of each other.
- **FSM**, states IDLE, SCAN and FLUSH:
  - **IDLE:** `ptr=0`, `irq_valid_o` low. Go to SCAN when any `pending` bit is set.
  - **SCAN:**
    - Each cycle, visit `ptr`. If `pending[ptr]` is set and either no candidate is held or `ptr` is earlier than the candidate, then `best` takes `ptr`.
    - At `ptr==NrParIrqs-1`, publish `irq_id_o=best` and `irq_valid_o=(best found and pending[best] still set)`. Then clear the candidate, set `ptr=0`, and repeat the pass.
    - Go to IDLE after a pass that finds nothing pending.
  - **FLUSH:** entered for one cycle after a completed claim. It clears `pending[irq_id_o]`, drops `irq_valid_o`, discards the partial pass, and resets `ptr=0`. Then go to SCAN, or to IDLE if nothing is pending.
- **Preemption:** `irq_id_o` may change at a pass boundary while `irq_valid_o` stays high. The core samples `irq_id_o` in the handshake cycle.
- **Simultaneous claim and edge on the same line:** the edge wins. The entry stays pending and reloads `abs_dl` from the current `time_q`.
- **Writes to `rel_dl` while pending:** they do not alter an armed `abs_dl`.
- **Writing `enable=0`:** it does not clear existing pending entries.

## Timing
- **Reset values:** `irq_valid_o=0`, `irq_id_o=0`, `pending=0`, `abs_dl=0`, `rel_dl=0`, `enable=0`, `time_q=0`, `irq_q=0`, FSM in IDLE.
- **Config write:** it takes effect the cycle after `cfg_req_i`.
- **Edge to `pending`:** `pending` is set one cycle after `irq_i` rises.
- **Edge to `irq_valid_o`:** with the FSM idle, `irq_valid_o` is high NrParIrqs+2 cycles after the `irq_i` rise. With a pass in progress, the worst case is 2·NrParIrqs+1 cycles.
- **Claim:** `irq_valid_o` is low the cycle after the handshake. A republish takes at least NrParIrqs+1 further cycles.
- **Reset mid-scan:** the asynchronous reset returns all state to the reset values immediately.

## Configuration
- **Macro `EDF_IC_DL_MISS_EN`:**
  - **Defined:** adds output port `dl_miss_o` (NrParIrqs bits, reset 0). `dl_miss_o[i]` is a sticky bit set when `pending[i]` and `time_q == abs_dl[i]`. A config write to `0x104` clears the bits set in `wdata` (write-1-to-clear). If a set and a clear hit the same bit in the same cycle, the set wins.
  - **Undefined:** the port and its logic are absent. A write to `0x104` is ignored.

## Structure
- **Package `edf_ic_pkg`:** config address constants (`ADDR_DL_BASE`, `ADDR_EN`, `ADDR_MISS`), the FSM state enum `sched_state_e`, and the default deadline width.
- **Sub-module `edf_dl_cmp`:** combinational wrap-aware comparator with inputs `a_dl`, `b_dl`, `a_id`, `b_id` and output `a_earlier`.

## Test plan
- **Reset, no config:** hold reset, release, pulse all `irq_i` lines. `irq_valid_o` must stay 0 (`enable=0`).
- **Ordering:** write `enable=1`, `rel_dl[0]=100`, `rel_dl[1]=20`, then raise `irq_i[0]` and `irq_i[1]` together. Required: `irq_valid_o=1` and `irq_id_o=1`. After the claim, id 0 must republish within NrParIrqs+1 cycles.
- **Tie:** write `rel_dl[0]=rel_dl[1]=50`, then raise both lines in the same cycle. `irq_id_o` must be 0.
- **Wrap-around:** force `time_q` near 0xFFF0 with DlWidth=16, write `rel_dl[0]=0x20` and `rel_dl[1]=0x05`, then raise both lines. `abs_dl[0]=0x0010` and `abs_dl[1]=0xFFF5`; `irq_id_o` must be 1.
- **Claim/edge collision:** raise `irq_i[1]` again (after a low cycle) in the exact cycle of its claim handshake. `pending[1]` must stay 1 with a reloaded deadline.
- **Deadline miss (with `EDF_IC_DL_MISS_EN`):** write `rel_dl[0]=3`, raise `irq_i[0]`, never assert ready. `dl_miss_o[0]=1` by cycle 5. A write to `0x104` with data 1 must clear it.
